// File: rtl/ysyx_22040386_fetch_queue.sv
// Instruction prefetch queue: issues in-order fetches, buffers returned words with
// their PCs, presents the head to IF/ID, and flushes on a MEM-stage redirect.
module ysyx_22040386_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic                     i_FQ_clk,
    input  logic                     i_FQ_rst_n,
    input  logic                     i_FQ_redirect,
    input  logic [63:0]              i_FQ_redirect_pc,
    input  logic                     i_FQ_stall,
    output logic                     o_FQ_mem_req_valid,
    output logic [63:0]              o_FQ_mem_req_addr,
    input  logic                     i_FQ_mem_req_ready,
    input  logic                     i_FQ_mem_rsp_valid,
    input  logic [31:0]              i_FQ_mem_rsp_data,
    output logic                     o_FQ_valid,
    output logic [63:0]              o_FQ_pc,
    output logic [31:0]              o_FQ_inst,
    output logic [4:0]               o_FQ_rs1,
    output logic [4:0]               o_FQ_rs2,
    output logic [$clog2(DEPTH):0]   o_FQ_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   NOP       = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_CR  = (CW + 1)'(DEPTH);

    logic [63:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] outst_reg;
    logic [CW-1:0] drop_reg;
    logic [63:0]   fetch_pc_reg;
    logic [63:0]   rsp_pc_reg;
    logic [63:0]   last_pc_reg;

    logic [CW-1:0] live;
    logic [CW:0]   credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic [CW-1:0] outst_next;
    logic [63:0]   redirect_pc_aligned;

    // Every live request owns a slot, so a response can never find the queue full.
    assign live   = outst_reg - drop_reg;
    assign credit = {1'b0, count_reg} + {1'b0, live};

    assign o_FQ_mem_req_valid = i_FQ_rst_n && (credit < DEPTH_CR) &&
                                (outst_reg < DEPTH_CNT) && !i_FQ_redirect;
    assign o_FQ_mem_req_addr  = fetch_pc_reg;

    assign accept     = o_FQ_mem_req_valid && i_FQ_mem_req_ready;
    assign head_valid = (count_reg != '0);
    assign pop        = head_valid && !i_FQ_stall && !i_FQ_redirect;
    assign push       = i_FQ_mem_rsp_valid && (drop_reg == '0) && !i_FQ_redirect;
    assign outst_next = outst_reg + CW'(accept) - CW'(i_FQ_mem_rsp_valid);

    assign redirect_pc_aligned = i_FQ_redirect_pc & ~64'h3;

    always_ff @(posedge i_FQ_clk) begin
        if (!i_FQ_rst_n) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            outst_reg    <= '0;
            drop_reg     <= '0;
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            last_pc_reg  <= RESET_PC;
        end else begin
            outst_reg <= outst_next;
            if (i_FQ_redirect) begin
                // Everything still in flight belongs to the wrong path.
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                count_reg    <= '0;
                drop_reg     <= outst_next;
                fetch_pc_reg <= redirect_pc_aligned;
                rsp_pc_reg   <= redirect_pc_aligned;
            end else begin
                if (accept) begin
                    fetch_pc_reg <= fetch_pc_reg + 64'd4;
                end
                if (i_FQ_mem_rsp_valid && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CW'(1);
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    rsp_pc_reg <= rsp_pc_reg + 64'd4;
                end
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + PW'(1);
                    last_pc_reg <= pc_mem[rd_ptr_reg];
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_FQ_clk) begin
        if (push && i_FQ_rst_n) begin
            pc_mem[wr_ptr_reg]   <= rsp_pc_reg;
            inst_mem[wr_ptr_reg] <= i_FQ_mem_rsp_data;
        end
    end

    assign o_FQ_valid = head_valid;
    assign o_FQ_inst  = head_valid ? inst_mem[rd_ptr_reg] : NOP;
    assign o_FQ_pc    = head_valid ? pc_mem[rd_ptr_reg] : last_pc_reg;
    assign o_FQ_rs1   = o_FQ_inst[19:15];
    assign o_FQ_rs2   = o_FQ_inst[24:20];
    assign o_FQ_count = count_reg;

endmodule
